// File: rtl/core_pkg.sv
// Shared encodings for the core memory stage: op/size codes, write-back
// extension selects, FSM states and the captured instruction record.
package core_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] MEM_OP_NONE  = 2'b00;
    localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
    localparam logic [1:0] MEM_OP_STORE = 2'b10;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    localparam logic [2:0] WB_SX_NONE = 3'd0;
    localparam logic [2:0] WB_SX_B    = 3'd1;
    localparam logic [2:0] WB_SX_H    = 3'd2;
    localparam logic [2:0] WB_SX_BU   = 3'd3;
    localparam logic [2:0] WB_SX_HU   = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [1:0]        op;
        logic [1:0]        size;
        logic [ADDR_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
        logic [31:0]       pc_4;
        logic [31:0]       sx_imm;
        logic [2:0]        sx_op;
        logic              mux;
        logic              we_rf;
        logic [4:0]        rd;
    } mem_instr_t;

endpackage

// File: rtl/core_mem_align.sv
// Byte-lane logic for the memory stage: byte enables, store lane steering,
// load right-alignment and misalignment detection. Purely combinational.
module core_mem_align
    import core_pkg::*;
(
    input  logic [1:0]        size_i,
    input  logic [1:0]        off_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [3:0]        be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              misalign_o
);

    always_comb begin
        be_o       = 4'b1111;
        wdata_o    = store_data_i;
        misalign_o = 1'b0;
        case (size_i)
            MEM_SIZE_BYTE: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            MEM_SIZE_HALF: begin
                be_o       = 4'b0011 << off_i;
                wdata_o    = {2{store_data_i[15:0]}};
                misalign_o = off_i[0];
            end
            default: misalign_o = (off_i != 2'b00);
        endcase
    end

    // Logical shift: upper bits are zero, write-back does the extension.
    assign rdata_o = rdata_i >> {off_i, 3'b000};

endmodule

// File: rtl/core_mem_s.sv
// Memory-access stage: issues L1D requests, stalls until ack, and registers
// the write-back operands into the MEM/WB pipeline register.
module core_mem_s
    import core_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid_in,
    input  logic [1:0]        mem_op_in,
    input  logic [1:0]        mem_size_in,
    input  logic [ADDR_W-1:0] mem_alu_result_in,
    input  logic [DATA_W-1:0] mem_store_data_in,
    input  logic [31:0]       mem_pc_4_in,
    input  logic [31:0]       mem_sx_imm_in,
    input  logic [2:0]        mem_sx_op_in,
    input  logic              mem_mux_in,
    input  logic              mem_we_reg_file_in,
    input  logic [4:0]        mem_rd_in,
    output logic              l1d_req_out,
    output logic              l1d_we_out,
    output logic [ADDR_W-1:0] l1d_addr_out,
    output logic [DATA_W-1:0] l1d_wdata_out,
    output logic [3:0]        l1d_be_out,
    input  logic              l1d_ack_in,
    input  logic [DATA_W-1:0] l1d_rdata_in,
    output logic [ADDR_W-1:0] wb_alu_result_out,
    output logic [DATA_W-1:0] wb_mem_data_out,
    output logic [31:0]       wb_pc_4_out,
    output logic [31:0]       wb_sx_imm_out,
    output logic [2:0]        wb_sx_op_out,
    output logic              wb_mux_out,
    output logic [4:0]        wb_rd_out,
    output logic              wb_we_reg_file_out,
    output logic              wb_ack_out,
    output logic              mem_stall_out,
    output logic              mem_misalign_out
);

    mem_state_e state_q, state_d;
    mem_instr_t lat_q, lat_d, in_instr, cur;
    logic       cur_valid, is_access, misalign, req, stall;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata, rdata_al;

    logic [ADDR_W-1:0] wb_alu_q, wb_alu_d;
    logic [DATA_W-1:0] wb_mem_q, wb_mem_d;
    logic [31:0]       wb_pc4_q, wb_pc4_d, wb_imm_q, wb_imm_d;
    logic [2:0]        wb_sx_q, wb_sx_d;
    logic              wb_mux_q, wb_mux_d, wb_we_q, wb_we_d, wb_ack_q, wb_ack_d;
    logic [4:0]        wb_rd_q, wb_rd_d;

    assign in_instr = '{op: mem_op_in, size: mem_size_in, alu_result: mem_alu_result_in,
                        store_data: mem_store_data_in, pc_4: mem_pc_4_in,
                        sx_imm: mem_sx_imm_in, sx_op: mem_sx_op_in, mux: mem_mux_in,
                        we_rf: mem_we_reg_file_in, rd: mem_rd_in};

    // While waiting, everything comes from the captured copy so upstream churn is invisible.
    assign cur       = (state_q == ST_WAIT) ? lat_q : in_instr;
    assign cur_valid = (state_q == ST_WAIT) ? 1'b1 : mem_valid_in;
    assign is_access = cur_valid && (cur.op == MEM_OP_LOAD || cur.op == MEM_OP_STORE);

    core_mem_align u_align (
        .size_i       (cur.size),
        .off_i        (cur.alu_result[1:0]),
        .store_data_i (cur.store_data),
        .rdata_i      (l1d_rdata_in),
        .be_o         (be),
        .wdata_o      (wdata),
        .rdata_o      (rdata_al),
        .misalign_o   (misalign)
    );

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        req     = 1'b0;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_access && !misalign) begin
                    req = 1'b1;
                    if (!l1d_ack_in) begin
                        stall   = 1'b1;
                        lat_d   = in_instr;
                        state_d = ST_WAIT;
                    end
                end
            end
            default: begin
                req   = 1'b1;
                stall = !l1d_ack_in;
                if (l1d_ack_in) state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wb_alu_d = wb_alu_q;
        wb_mem_d = wb_mem_q;
        wb_pc4_d = wb_pc4_q;
        wb_imm_d = wb_imm_q;
        wb_sx_d  = wb_sx_q;
        wb_mux_d = wb_mux_q;
        wb_rd_d  = wb_rd_q;
        wb_we_d  = 1'b0;
        wb_ack_d = 1'b0;
        if (!stall) begin
            wb_alu_d = cur.alu_result;
            wb_mem_d = rdata_al;
            wb_pc4_d = cur.pc_4;
            wb_imm_d = cur.sx_imm;
            wb_sx_d  = cur.sx_op;
            wb_mux_d = cur.mux;
            wb_rd_d  = cur.rd;
            wb_we_d  = cur_valid && cur.we_rf && cur.op != MEM_OP_STORE
                       && !(is_access && misalign);
            wb_ack_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            lat_q    <= '0;
            wb_alu_q <= '0;
            wb_mem_q <= '0;
            wb_pc4_q <= '0;
            wb_imm_q <= '0;
            wb_sx_q  <= '0;
            wb_mux_q <= 1'b0;
            wb_rd_q  <= '0;
            wb_we_q  <= 1'b0;
            wb_ack_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            wb_alu_q <= wb_alu_d;
            wb_mem_q <= wb_mem_d;
            wb_pc4_q <= wb_pc4_d;
            wb_imm_q <= wb_imm_d;
            wb_sx_q  <= wb_sx_d;
            wb_mux_q <= wb_mux_d;
            wb_rd_q  <= wb_rd_d;
            wb_we_q  <= wb_we_d;
            wb_ack_q <= wb_ack_d;
        end
    end

    // Gating with rst_n drops the request the instant reset asserts.
    assign l1d_req_out      = req && rst_n;
    assign l1d_we_out       = cur.op == MEM_OP_STORE;
    assign l1d_addr_out     = {cur.alu_result[ADDR_W-1:2], 2'b00};
    assign l1d_wdata_out    = wdata;
    assign l1d_be_out       = be;
    assign mem_stall_out    = stall;
    assign mem_misalign_out = (state_q == ST_IDLE) && is_access && misalign;

    assign wb_alu_result_out  = wb_alu_q;
    assign wb_mem_data_out    = wb_mem_q;
    assign wb_pc_4_out        = wb_pc4_q;
    assign wb_sx_imm_out      = wb_imm_q;
    assign wb_sx_op_out       = wb_sx_q;
    assign wb_mux_out         = wb_mux_q;
    assign wb_rd_out          = wb_rd_q;
    assign wb_we_reg_file_out = wb_we_q;
    assign wb_ack_out         = wb_ack_q;

endmodule

// File: tb/tb_core_mem_s.sv
// Directed bench for core_mem_s: ALU pass-through, loads/stores with varying
// ack latency, misalignment and reset during an outstanding access.
module tb_core_mem_s;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid_in = 1'b0;
    logic [1:0]  mem_op_in = 2'b00, mem_size_in = 2'b00;
    logic [31:0] mem_alu_result_in = '0, mem_store_data_in = '0;
    logic [31:0] mem_pc_4_in = '0, mem_sx_imm_in = '0;
    logic [2:0]  mem_sx_op_in = '0;
    logic        mem_mux_in = 1'b0, mem_we_reg_file_in = 1'b0;
    logic [4:0]  mem_rd_in = '0;
    logic        l1d_req_out, l1d_we_out, l1d_ack_in = 1'b0;
    logic [31:0] l1d_addr_out, l1d_wdata_out, l1d_rdata_in = '0;
    logic [3:0]  l1d_be_out;
    logic [31:0] wb_alu_result_out, wb_mem_data_out, wb_pc_4_out, wb_sx_imm_out;
    logic [2:0]  wb_sx_op_out;
    logic        wb_mux_out, wb_we_reg_file_out, wb_ack_out;
    logic [4:0]  wb_rd_out;
    logic        mem_stall_out, mem_misalign_out;

    int checks = 0;
    int failures = 0;

    core_mem_s dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid_in(mem_valid_in), .mem_op_in(mem_op_in), .mem_size_in(mem_size_in),
        .mem_alu_result_in(mem_alu_result_in), .mem_store_data_in(mem_store_data_in),
        .mem_pc_4_in(mem_pc_4_in), .mem_sx_imm_in(mem_sx_imm_in), .mem_sx_op_in(mem_sx_op_in),
        .mem_mux_in(mem_mux_in), .mem_we_reg_file_in(mem_we_reg_file_in), .mem_rd_in(mem_rd_in),
        .l1d_req_out(l1d_req_out), .l1d_we_out(l1d_we_out), .l1d_addr_out(l1d_addr_out),
        .l1d_wdata_out(l1d_wdata_out), .l1d_be_out(l1d_be_out),
        .l1d_ack_in(l1d_ack_in), .l1d_rdata_in(l1d_rdata_in),
        .wb_alu_result_out(wb_alu_result_out), .wb_mem_data_out(wb_mem_data_out),
        .wb_pc_4_out(wb_pc_4_out), .wb_sx_imm_out(wb_sx_imm_out), .wb_sx_op_out(wb_sx_op_out),
        .wb_mux_out(wb_mux_out), .wb_rd_out(wb_rd_out),
        .wb_we_reg_file_out(wb_we_reg_file_out), .wb_ack_out(wb_ack_out),
        .mem_stall_out(mem_stall_out), .mem_misalign_out(mem_misalign_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] sz,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic mux, input logic we, input logic [4:0] rd);
        mem_valid_in       = v;
        mem_op_in          = op;
        mem_size_in        = sz;
        mem_alu_result_in  = alu;
        mem_store_data_in  = sd;
        mem_mux_in         = mux;
        mem_we_reg_file_in = we;
        mem_rd_in          = rd;
        mem_pc_4_in        = alu + 32'd4;
        mem_sx_imm_in      = 32'h0000_0010;
        mem_sx_op_in       = WB_SX_NONE;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_wb_ack", 32'(wb_ack_out), 32'd1);
        chk("rst_wb_we", 32'(wb_we_reg_file_out), 32'd0);
        chk("rst_wb_alu", wb_alu_result_out, 32'h0);
        chk("rst_req", 32'(l1d_req_out), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // ALU op pass-through
        drive(1, MEM_OP_NONE, MEM_SIZE_WORD, 32'h1234, 32'h0, 1, 1, 5'd5);
        #1;
        chk("alu_req", 32'(l1d_req_out), 32'd0);
        chk("alu_stall", 32'(mem_stall_out), 32'd0);
        @(posedge clk); #1;
        chk("alu_wb_alu", wb_alu_result_out, 32'h1234);
        chk("alu_wb_we", 32'(wb_we_reg_file_out), 32'd1);
        chk("alu_wb_ack", 32'(wb_ack_out), 32'd1);
        chk("alu_wb_rd", 32'(wb_rd_out), 32'd5);
        chk("alu_wb_pc4", wb_pc_4_out, 32'h1238);

        // Load word, same-cycle ack
        @(negedge clk);
        drive(1, MEM_OP_LOAD, MEM_SIZE_WORD, 32'h100, 32'h0, 0, 1, 5'd6);
        l1d_ack_in = 1'b1; l1d_rdata_in = 32'hDEAD_BEEF;
        #1;
        chk("lw_req", 32'(l1d_req_out), 32'd1);
        chk("lw_stall", 32'(mem_stall_out), 32'd0);
        chk("lw_addr", l1d_addr_out, 32'h100);
        chk("lw_be", 32'(l1d_be_out), 32'hF);
        chk("lw_we", 32'(l1d_we_out), 32'd0);
        @(posedge clk); #1;
        chk("lw_wb_data", wb_mem_data_out, 32'hDEAD_BEEF);
        chk("lw_wb_we", 32'(wb_we_reg_file_out), 32'd1);

        // Load byte at 0x103, ack after three stall cycles
        @(negedge clk);
        l1d_ack_in = 1'b0; l1d_rdata_in = 32'h0;
        drive(1, MEM_OP_LOAD, MEM_SIZE_BYTE, 32'h103, 32'h0, 0, 1, 5'd7);
        #1;
        chk("lb_addr", l1d_addr_out, 32'h100);
        chk("lb_be", 32'(l1d_be_out), 32'h8);
        for (int i = 0; i < 3; i++) begin
            chk("lb_stall", 32'(mem_stall_out), 32'd1);
            chk("lb_req", 32'(l1d_req_out), 32'd1);
            @(posedge clk); #1;
            chk("lb_wb_ack_stall", 32'(wb_ack_out), 32'd0);
            chk("lb_wb_we_stall", 32'(wb_we_reg_file_out), 32'd0);
            @(negedge clk);
            drive(1, MEM_OP_STORE, MEM_SIZE_WORD, 32'h555 + 32'(i), 32'hFFFF_FFFF, 1, 0, 5'd9);
            #1;
            chk("lb_addr_held", l1d_addr_out, 32'h100);
            chk("lb_be_held", 32'(l1d_be_out), 32'h8);
            chk("lb_we_held", 32'(l1d_we_out), 32'd0);
        end
        l1d_ack_in = 1'b1; l1d_rdata_in = 32'h80AA_BBCC;
        #1;
        chk("lb_ack_stall", 32'(mem_stall_out), 32'd0);
        chk("lb_ack_req", 32'(l1d_req_out), 32'd1);
        @(posedge clk); #1;
        chk("lb_wb_data", wb_mem_data_out, 32'h0000_0080);
        chk("lb_wb_rd", 32'(wb_rd_out), 32'd7);
        chk("lb_wb_alu", wb_alu_result_out, 32'h103);
        chk("lb_wb_ack", 32'(wb_ack_out), 32'd1);
        chk("lb_wb_we", 32'(wb_we_reg_file_out), 32'd1);

        // Invalid instruction -> bubble
        @(negedge clk);
        l1d_ack_in = 1'b0;
        drive(0, MEM_OP_LOAD, MEM_SIZE_WORD, 32'h40, 32'h0, 0, 1, 5'd3);
        #1;
        chk("bub_req", 32'(l1d_req_out), 32'd0);
        @(posedge clk); #1;
        chk("bub_wb_we", 32'(wb_we_reg_file_out), 32'd0);
        chk("bub_wb_ack", 32'(wb_ack_out), 32'd1);

        // Store half 0xBEEF at 0x202, ack next cycle
        @(negedge clk);
        drive(1, MEM_OP_STORE, MEM_SIZE_HALF, 32'h202, 32'h0000_BEEF, 0, 1, 5'd8);
        #1;
        chk("sh_be", 32'(l1d_be_out), 32'hC);
        chk("sh_wdata_hi", 32'(l1d_wdata_out[31:16]), 32'hBEEF);
        chk("sh_we", 32'(l1d_we_out), 32'd1);
        chk("sh_addr", l1d_addr_out, 32'h200);
        chk("sh_stall", 32'(mem_stall_out), 32'd1);
        @(negedge clk);
        l1d_ack_in = 1'b1;
        #1;
        chk("sh_ack_stall", 32'(mem_stall_out), 32'd0);
        @(posedge clk); #1;
        chk("sh_wb_we", 32'(wb_we_reg_file_out), 32'd0);
        chk("sh_wb_ack", 32'(wb_ack_out), 32'd1);

        // Store byte at 0x301, same-cycle ack: lane replication
        @(negedge clk);
        drive(1, MEM_OP_STORE, MEM_SIZE_BYTE, 32'h301, 32'h0000_00A5, 0, 0, 5'd0);
        #1;
        chk("sb_be", 32'(l1d_be_out), 32'h2);
        chk("sb_wdata_lane1", 32'(l1d_wdata_out[15:8]), 32'hA5);

        // Misaligned load word at 0x101
        @(negedge clk);
        l1d_ack_in = 1'b0;
        drive(1, MEM_OP_LOAD, MEM_SIZE_WORD, 32'h101, 32'h0, 0, 1, 5'd4);
        #1;
        chk("mis_pulse", 32'(mem_misalign_out), 32'd1);
        chk("mis_req", 32'(l1d_req_out), 32'd0);
        chk("mis_stall", 32'(mem_stall_out), 32'd0);
        @(posedge clk); #1;
        chk("mis_wb_we", 32'(wb_we_reg_file_out), 32'd0);
        chk("mis_wb_ack", 32'(wb_ack_out), 32'd1);
        @(negedge clk);
        drive(1, MEM_OP_LOAD, MEM_SIZE_HALF, 32'h106, 32'h0, 0, 1, 5'd4);
        l1d_ack_in = 1'b1; l1d_rdata_in = 32'h1122_3344;
        #1;
        chk("half_ok_mis", 32'(mem_misalign_out), 32'd0);
        @(posedge clk); #1;
        chk("half_ok_data", wb_mem_data_out, 32'h0000_1122);

        // Reset during WAIT, late ack afterwards
        @(negedge clk);
        l1d_ack_in = 1'b0;
        drive(1, MEM_OP_LOAD, MEM_SIZE_WORD, 32'h300, 32'h0, 0, 1, 5'd2);
        @(posedge clk); #1;
        chk("rw_stall", 32'(mem_stall_out), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rw_req_drop", 32'(l1d_req_out), 32'd0);
        chk("rw_wb_ack", 32'(wb_ack_out), 32'd1);
        drive(0, MEM_OP_NONE, MEM_SIZE_WORD, 32'h0, 32'h0, 0, 0, 5'd0);
        l1d_ack_in = 1'b1; l1d_rdata_in = 32'hCAFE_F00D;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("late_ack_req", 32'(l1d_req_out), 32'd0);
        chk("late_ack_stall", 32'(mem_stall_out), 32'd0);
        @(posedge clk); #1;
        chk("late_ack_wb_we", 32'(wb_we_reg_file_out), 32'd0);
        chk("late_ack_wb_ack", 32'(wb_ack_out), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
